// File: rtl/dmem_arbiter.sv
// Data memory arbiter between the MEM stage and a debug access port.
// Core wins by default; a starved debug request forces a one-cycle core stall.
module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_core_rd_en,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_rd_addr,
    input  logic                       in_core_wr_en,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word,
    output logic [DMEM_WORD_WIDTH-1:0] out_core_rd_word,
    output logic                       out_core_stall,
    input  logic                       in_dbg_req,
    input  logic                       in_dbg_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dbg_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dbg_wdata,
    output logic                       out_dbg_ack,
    output logic                       out_dbg_rvalid,
    output logic [DMEM_WORD_WIDTH-1:0] out_dbg_rdata,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
    output logic                       out_mem_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word
);

    typedef enum logic {
        IDLE,
        FORCE
    } state_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e                     state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       rvalid_q, rvalid_d;
    logic [DMEM_WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                       core_active;
    logic                       ack;

    assign core_active = in_core_rd_en | in_core_wr_en;

    // Grant decision, starvation counter and IDLE/FORCE transitions
    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ack = in_dbg_req & ~core_active;
                if (in_dbg_req && !ack) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == LIMIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                // Either granted now or abandoned; both end the stall
                ack     = in_dbg_req;
                state_d = IDLE;
            end
        endcase
    end

    // Debug read return: memory data arrives the cycle after the grant
    always_comb begin
        rvalid_d = ack & ~in_dbg_we;
        rdata_d  = rvalid_q ? in_mem_rd_word : rdata_q;
    end

    // State, counter and read-return registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memory port steering: debug on grant, core otherwise
    always_comb begin
        if (ack) begin
            out_mem_rd_addr  = in_dbg_addr;
            out_mem_wr_addr  = in_dbg_addr;
            out_mem_wr_word  = in_dbg_wdata;
            out_mem_write_en = in_dbg_we;
        end else begin
            out_mem_rd_addr  = in_core_rd_addr;
            out_mem_wr_addr  = in_core_wr_addr;
            out_mem_wr_word  = in_core_wr_word;
            out_mem_write_en = in_core_wr_en;
        end
    end

    assign out_dbg_ack      = ack;
    assign out_core_stall   = (state_q == FORCE);
    assign out_core_rd_word = in_mem_rd_word;
    assign out_dbg_rvalid   = rvalid_q;
    // Live memory word in the return cycle, held copy afterwards
    assign out_dbg_rdata    = rvalid_q ? in_mem_rd_word : rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors, behavioural data memory,
// debug read data checked through an expected-value queue.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_rd_en, core_wr_en;
    logic [AW-1:0] core_rd_addr, core_wr_addr;
    logic [WW-1:0] core_wr_word, core_rd_word;
    logic          core_stall;
    logic          dbg_req, dbg_we, dbg_ack, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [WW-1:0] dbg_wdata, dbg_rdata;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [WW-1:0] mem_wr_word, mem_rd_word;
    logic          mem_we;

    logic [WW-1:0] mem [0:(1<<AW)-1];
    logic [WW-1:0] exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH(AW),
        .DMEM_WORD_WIDTH(WW),
        .STARVE_LIMIT(8)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .in_core_rd_en(core_rd_en),
        .in_core_rd_addr(core_rd_addr),
        .in_core_wr_en(core_wr_en),
        .in_core_wr_addr(core_wr_addr),
        .in_core_wr_word(core_wr_word),
        .out_core_rd_word(core_rd_word),
        .out_core_stall(core_stall),
        .in_dbg_req(dbg_req),
        .in_dbg_we(dbg_we),
        .in_dbg_addr(dbg_addr),
        .in_dbg_wdata(dbg_wdata),
        .out_dbg_ack(dbg_ack),
        .out_dbg_rvalid(dbg_rvalid),
        .out_dbg_rdata(dbg_rdata),
        .out_mem_rd_addr(mem_rd_addr),
        .out_mem_wr_addr(mem_wr_addr),
        .out_mem_wr_word(mem_wr_word),
        .out_mem_write_en(mem_we),
        .in_mem_rd_word(mem_rd_word)
    );

    always #5 clk = ~clk;

    // Registered-read data memory
    always @(posedge clk) begin
        if (mem_we) mem[mem_wr_addr] <= mem_wr_word;
        mem_rd_word <= mem[mem_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Debug read-return monitor
    always @(negedge clk) begin
        if (rst_n && dbg_rvalid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h expected no rvalid",
                         dbg_rdata);
            end else begin
                chk("dbg_rdata", dbg_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic idle_in();
        core_rd_en = 0; core_rd_addr = '0;
        core_wr_en = 0; core_wr_addr = '0; core_wr_word = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic dbg_set(input logic we, input logic [AW-1:0] a,
                           input logic [WW-1:0] d);
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] pa [5];
        logic [WW-1:0] pd [5];
        pa = '{12'h010, 12'h030, 12'h040, 12'h060, 12'h020};
        pd = '{16'hBEEF, 16'h0C30, 16'hA5A5, 16'h0000, 16'h0000};
        idle_in();

        // reset state
        neg();
        chk("rst_stall", core_stall, 0);
        chk("rst_rvalid", dbg_rvalid, 0);
        chk("rst_rdata", dbg_rdata, 0);
        chk("rst_ack", dbg_ack, 0);
        tick();
        rst_n = 1;

        // preload via back-to-back debug writes, core idle
        for (int i = 0; i < 5; i++) begin
            dbg_set(1, pa[i], pd[i]);
            neg();
            chk("pre_ack", dbg_ack, 1);
            chk("pre_we", mem_we, 1);
            tick();
        end
        idle_in();

        // debug read with idle core
        dbg_set(0, 12'h010, 0);
        neg();
        chk("rd_ack", dbg_ack, 1);
        chk("rd_addr", mem_rd_addr, 12'h010);
        chk("rd_we", mem_we, 0);
        exp_q.push_back(16'hBEEF);
        tick();
        idle_in();
        core_rd_en = 1; core_rd_addr = 12'h030;
        neg();
        chk("rd_ack_next", dbg_ack, 0);
        tick();
        idle_in();
        neg();
        chk("rvalid_pulse", dbg_rvalid, 0);
        chk("rdata_hold", dbg_rdata, 16'hBEEF);
        chk("core_rd_word", core_rd_word, 16'h0C30);
        tick();

        // simultaneous core and debug write to the same address
        core_wr_en = 1; core_wr_addr = 12'h020; core_wr_word = 16'h1234;
        dbg_set(1, 12'h020, 16'h5555);
        neg();
        chk("coll_ack", dbg_ack, 0);
        chk("coll_we", mem_we, 1);
        chk("coll_word", mem_wr_word, 16'h1234);
        chk("coll_addr", mem_wr_addr, 12'h020);
        tick();
        core_wr_en = 0;
        neg();
        chk("coll_dbg_ack", dbg_ack, 1);
        chk("coll_dbg_word", mem_wr_word, 16'h5555);
        chk("coll_dbg_we", mem_we, 1);
        tick();
        dbg_set(0, 12'h020, 0);
        neg();
        chk("coll_rd_ack", dbg_ack, 1);
        exp_q.push_back(16'h5555);
        tick();
        idle_in();
        tick();

        // starvation: core reads continuously
        core_rd_en = 1; core_rd_addr = 12'h030;
        dbg_set(0, 12'h040, 0);
        for (int i = 0; i < 8; i++) begin
            neg();
            chk("starve_ack", dbg_ack, 0);
            chk("starve_stall", core_stall, 0);
            if (i == 1) chk("starve_core_rd", core_rd_word, 16'h0C30);
            tick();
        end
        neg();
        chk("force_stall", core_stall, 1);
        chk("force_ack", dbg_ack, 1);
        chk("force_addr", mem_rd_addr, 12'h040);
        exp_q.push_back(16'hA5A5);
        tick();
        idle_in();
        neg();
        chk("force_exit", core_stall, 0);
        tick();

        // debug request abandoned in FORCE
        core_wr_en = 1; core_wr_addr = 12'h050; core_wr_word = 16'h1111;
        dbg_set(1, 12'h060, 16'h7777);
        repeat (8) begin
            neg();
            chk("ab_ack", dbg_ack, 0);
            tick();
        end
        dbg_req = 0;
        neg();
        chk("ab_stall", core_stall, 1);
        chk("ab_ack0", dbg_ack, 0);
        chk("ab_wr_addr", mem_wr_addr, 12'h050);
        tick();
        neg();
        chk("ab_exit", core_stall, 0);
        chk("ab_nowrite", mem[12'h060], 16'h0000);
        tick();
        dbg_req = 1;
        for (int i = 0; i < 8; i++) begin
            neg();
            chk("ab_cnt_ack", dbg_ack, 0);
            chk("ab_cnt_stall", core_stall, 0);
            tick();
        end
        neg();
        chk("ab2_stall", core_stall, 1);
        chk("ab2_ack", dbg_ack, 1);
        chk("ab2_addr", mem_wr_addr, 12'h060);
        chk("ab2_word", mem_wr_word, 16'h7777);
        tick();
        idle_in();
        neg();
        chk("ab2_exit", core_stall, 0);
        chk("ab2_mem", mem[12'h060], 16'h7777);
        tick();

        // reset during FORCE
        core_rd_en = 1; core_rd_addr = 12'h030;
        dbg_set(0, 12'h040, 0);
        repeat (8) tick();
        neg();
        chk("rf_stall", core_stall, 1);
        #1 rst_n = 0;
        #1 chk("rf_stall_rst", core_stall, 0);
        idle_in();
        tick();
        rst_n = 1;

        // reset with a pending debug read return
        dbg_set(0, 12'h010, 0);
        neg();
        chk("rr_ack", dbg_ack, 1);
        tick();
        rst_n = 0;
        #1;
        chk("rr_rvalid_rst", dbg_rvalid, 0);
        chk("rr_rdata_rst", dbg_rdata, 0);
        idle_in();
        tick();
        rst_n = 1;
        repeat (3) begin
            neg();
            chk("rr_rvalid_after", dbg_rvalid, 0);
            tick();
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DMEM_ADDR_WIDTH, default 12, data memory address width.
REQ-002 SHALL have parameter DMEM_WORD_WIDTH, default 16, data memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, the count of consecutive ungranted debug-request cycles that forces a core stall (legal range 1..255).
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port list (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_core_rd_en  in  1  MEM-stage read request
- in_core_rd_addr  in  DMEM_ADDR_WIDTH  MEM-stage read address
- in_core_wr_en  in  1  MEM-stage write request
- in_core_wr_addr  in  DMEM_ADDR_WIDTH  MEM-stage write address
- in_core_wr_word  in  DMEM_WORD_WIDTH  MEM-stage write data
- out_core_rd_word  out  DMEM_WORD_WIDTH  read data to the MEM stage
- out_core_stall  out  1  freeze request to the pipeline
- in_dbg_req  in  1  debug access request
- in_dbg_we  in  1  debug write (1) or read (0)
- in_dbg_addr  in  DMEM_ADDR_WIDTH  debug address
- in_dbg_wdata  in  DMEM_WORD_WIDTH  debug write data
- out_dbg_ack  out  1  debug request granted this cycle
- out_dbg_rvalid  out  1  debug read data valid
- out_dbg_rdata  out  DMEM_WORD_WIDTH  debug read data
- out_mem_rd_addr  out  DMEM_ADDR_WIDTH  to dmem read address
- out_mem_wr_addr  out  DMEM_ADDR_WIDTH  to dmem write address
- out_mem_wr_word  out  DMEM_WORD_WIDTH  to dmem write data
- out_mem_write_en  out  1  to dmem write enable
- in_mem_rd_word  in  DMEM_WORD_WIDTH  dmem read data (1-cycle registered read)

Function
REQ-006 The core is active in a cycle when in_core_rd_en or in_core_wr_en is 1.
REQ-007 FSM states: IDLE and FORCE; state, counter, stall, rvalid and rdata are registered.
REQ-008 In IDLE, out_dbg_ack SHALL be 1 (combinational) iff in_dbg_req=1 and the core is not active.
REQ-009 In FORCE, out_dbg_ack SHALL equal in_dbg_req, regardless of core activity.
REQ-010 In a cycle with ack=1, memory outputs SHALL come from the debug port: rd_addr=in_dbg_addr, wr_addr=in_dbg_addr, wr_word=in_dbg_wdata, write_en=in_dbg_we.
REQ-011 In any other cycle, memory outputs SHALL come from the core: write_en=in_core_wr_en, and the addresses and data are passed through.
REQ-012 out_core_rd_word SHALL equal in_mem_rd_word combinationally at all times.
REQ-013 A debug read grant (ack=1, we=0) SHALL produce out_dbg_rvalid=1 exactly 1 cycle later, with out_dbg_rdata=in_mem_rd_word sampled in that cycle. rdata SHALL hold its value otherwise; rvalid SHALL be a single-cycle pulse.
REQ-014 The debug side SHALL hold req, we, addr and wdata stable until ack. A request is consumed in its ack cycle; back-to-back grants are allowed.
REQ-015 An 8-bit wait counter SHALL increment each cycle with in_dbg_req=1 and ack=0. It SHALL clear on ack or when in_dbg_req=0.
REQ-016 IDLE->FORCE SHALL occur at the clock edge where the counter would reach STARVE_LIMIT. out_core_stall SHALL be 1 exactly while in FORCE.
REQ-017 FORCE->IDLE SHALL occur on ack or when in_dbg_req=0 (abandoned request, no access made).
REQ-018 The core SHALL hold its request while stalled. The arbiter does not buffer core accesses, and a core access in a FORCE ack cycle is ignored.
REQ-019 Simultaneous core and debug requests in IDLE: the core wins and debug waits.

Reset
REQ-020 On reset=0 (asynchronous), the FSM SHALL enter IDLE, the counter=0, out_core_stall=0, out_dbg_rvalid=0 and out_dbg_rdata=0. The combinational outputs follow REQ-008..012.
REQ-021 Reset asserted mid-FORCE or with a pending rvalid SHALL drop stall and rvalid immediately; no pending debug read is returned after reset release.

Verification
REQ-022 Core idle, debug read of addr 0x010 holding 0xBEEF -> ack in the same cycle, rvalid=1 and rdata=0xBEEF 1 cycle later.
REQ-023 Core write 0x1234 to 0x020 together with a debug write 0x5555 to 0x020 -> core write is issued, ack=0, debug write is issued next idle cycle, final mem[0x020]=0x5555.
REQ-024 Core continuously active, debug req held, STARVE_LIMIT=8 -> stall=1 after 8 ungranted cycles, ack in the first FORCE cycle, stall=0 the following cycle.
REQ-025 Debug req dropped while in FORCE -> return to IDLE, stall=0, no mem write, counter=0.
REQ-026 Reset pulsed low during FORCE and 1 cycle after a debug read ack -> stall=0 and rvalid=0 immediately; rvalid stays 0 after release.
